// File: rtl/rx_frame_sequencer_pkg.sv
// Shared types and default constants for the BPSK receive frame sequencer.
// The sync constants live beside the packet size so both ends agree on framing.
package rx_frame_sequencer_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int          DEF_PACKET_SIZE = 8;
    localparam int          DEF_SYNC_WIDTH  = 8;
    localparam logic [7:0]  DEF_SYNC_WORD   = 8'hA5;
    localparam int          DEF_FRAME_PKTS  = 2;
    localparam int          DEF_GAP_TIMEOUT = 64;

endpackage

// File: rtl/rx_frame_sequencer_sync_correlator.sv
// Sync word correlator: shifts demodulated bits in LSB-first and flags when the
// post-shift window equals the sync pattern (first-received bit ends up in the MSB).
module sync_correlator
    import rx_frame_sequencer_pkg::*;
#(
    parameter int                    SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = DEF_SYNC_WORD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_data,
    output logic match
);

    // Only the newest SYNC_WIDTH-1 bits need storing; the incoming bit completes the window.
    logic [SYNC_WIDTH-2:0] history_r;
    logic [SYNC_WIDTH-1:0] window_s;

    assign window_s = {history_r, bit_data};
    assign match    = bit_valid & ~clr & (window_s == SYNC_WORD);

    // History register: cleared while locked or disabled so a new lock needs fresh bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history_r <= '0;
        end else if (clr) begin
            history_r <= '0;
        end else if (bit_valid) begin
            history_r <= window_s[SYNC_WIDTH-2:0];
        end else begin
            history_r <= history_r;
        end
    end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive frame sequencer: hunts for the sync word, assembles FRAME_PKTS packets
// per lock and hands them downstream on valid/ready, flagging gap timeouts and overruns.
module rx_frame_sequencer
    import rx_frame_sequencer_pkg::*;
#(
    parameter int                    PACKET_SIZE = DEF_PACKET_SIZE,
    parameter int                    SYNC_WIDTH  = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int                    FRAME_PKTS  = DEF_FRAME_PKTS,
    parameter int                    GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   bit_valid,
    input  logic                   bit_data,
    output logic [PACKET_SIZE-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   sync_lock,
    output logic                   timeout_err,
    output logic                   overrun_err,
    output logic [7:0]             frame_count
);

    localparam int BW = $clog2(PACKET_SIZE + 1);
    localparam int PW = $clog2(FRAME_PKTS + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    state_t                 state_r, state_nxt_s;
    logic [BW-1:0]          bit_cnt_r, bit_cnt_nxt_s;
    logic [PW-1:0]          pkt_cnt_r, pkt_cnt_nxt_s;
    logic [GW-1:0]          gap_cnt_r, gap_cnt_nxt_s;
    logic [PACKET_SIZE-2:0] pkt_sr_r, pkt_sr_nxt_s;
    logic [PACKET_SIZE-1:0] packet_s;
    logic                   match_s;
    logic                   corr_clr_s;
    logic                   transfer_s;
    logic                   load_s;
    logic                   timeout_s;
    logic                   overrun_s;
    logic                   frame_inc_s;

    logic [PACKET_SIZE-1:0] pkt_data_r;
    logic                   pkt_valid_r;
    logic                   sync_lock_r;
    logic                   timeout_err_r;
    logic                   overrun_err_r;
    logic [7:0]             frame_count_r;

    assign corr_clr_s = (state_r == COLLECT) | ~enable;
    assign packet_s   = {pkt_sr_r, bit_data};
    assign transfer_s = pkt_valid_r & pkt_ready;

    sync_correlator #(
        .SYNC_WIDTH (SYNC_WIDTH),
        .SYNC_WORD  (SYNC_WORD)
    ) u_sync_correlator (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (corr_clr_s),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .match     (match_s)
    );

    // Next-state, counter and event decode for the HUNT/COLLECT sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        pkt_cnt_nxt_s = pkt_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        pkt_sr_nxt_s  = pkt_sr_r;
        load_s        = 1'b0;
        timeout_s     = 1'b0;
        overrun_s     = 1'b0;
        frame_inc_s   = 1'b0;

        case (state_r)
            HUNT: begin
                bit_cnt_nxt_s = '0;
                pkt_cnt_nxt_s = '0;
                gap_cnt_nxt_s = '0;
                pkt_sr_nxt_s  = '0;
                if (match_s) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_nxt_s   = HUNT;
                    bit_cnt_nxt_s = '0;
                    pkt_cnt_nxt_s = '0;
                    gap_cnt_nxt_s = '0;
                    pkt_sr_nxt_s  = '0;
                end else if (bit_valid) begin
                    gap_cnt_nxt_s = '0;
                    if (bit_cnt_r == BW'(PACKET_SIZE - 1)) begin
                        bit_cnt_nxt_s = '0;
                        pkt_sr_nxt_s  = '0;
                        if (!pkt_valid_r || transfer_s) begin
                            load_s = 1'b1;
                            if (pkt_cnt_r == PW'(FRAME_PKTS - 1)) begin
                                state_nxt_s   = HUNT;
                                pkt_cnt_nxt_s = '0;
                                frame_inc_s   = 1'b1;
                            end else begin
                                pkt_cnt_nxt_s = pkt_cnt_r + PW'(1);
                            end
                        end else begin
                            // Downstream still holds the previous packet: drop this one.
                            overrun_s     = 1'b1;
                            state_nxt_s   = HUNT;
                            pkt_cnt_nxt_s = '0;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                        pkt_sr_nxt_s  = packet_s[PACKET_SIZE-2:0];
                    end
                end else if (gap_cnt_r >= GW'(GAP_TIMEOUT)) begin
                    timeout_s     = 1'b1;
                    state_nxt_s   = HUNT;
                    bit_cnt_nxt_s = '0;
                    pkt_cnt_nxt_s = '0;
                    gap_cnt_nxt_s = '0;
                    pkt_sr_nxt_s  = '0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_nxt_s   = HUNT;
                bit_cnt_nxt_s = '0;
                pkt_cnt_nxt_s = '0;
                gap_cnt_nxt_s = '0;
                pkt_sr_nxt_s  = '0;
            end
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= HUNT;
            bit_cnt_r <= '0;
            pkt_cnt_r <= '0;
            gap_cnt_r <= '0;
            pkt_sr_r  <= '0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            pkt_cnt_r <= pkt_cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            pkt_sr_r  <= pkt_sr_nxt_s;
        end
    end

    // Output holding stage: a new packet may load in the same cycle the old one transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_data_r  <= '0;
            pkt_valid_r <= 1'b0;
        end else if (load_s) begin
            pkt_data_r  <= packet_s;
            pkt_valid_r <= 1'b1;
        end else if (transfer_s) begin
            pkt_data_r  <= pkt_data_r;
            pkt_valid_r <= 1'b0;
        end else begin
            pkt_data_r  <= pkt_data_r;
            pkt_valid_r <= pkt_valid_r;
        end
    end

    // Status flags, error pulses and the delivered-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_lock_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            sync_lock_r   <= (state_nxt_s == COLLECT);
            timeout_err_r <= timeout_s;
            overrun_err_r <= overrun_s;
            if (frame_inc_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign pkt_data    = pkt_data_r;
    assign pkt_valid   = pkt_valid_r;
    assign sync_lock   = sync_lock_r;
    assign timeout_err = timeout_err_r;
    assign overrun_err = overrun_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: directed scenarios plus random traffic, checked by a
// scoreboard fed from a frame-level reference model.
module tb_rx_frame_sequencer;

    localparam int SYNC    = 8'hA5;
    localparam int NPKTS   = 2;
    localparam int GAP_MAX = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       pkt_ready = 1'b0;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       sync_lock;
    logic       timeout_err;
    logic       overrun_err;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    rx_frame_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .sync_lock   (sync_lock),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the receiver (locked or hunting, bits so far).
    int m_cyc = 0;
    int m_locked = 0, m_hist = 0, m_cur = 0, m_nbits = 0, m_npk = 0, m_idle = 0;
    int m_full = 0, m_held = 0, m_frames = 0;
    int m_xfer, m_load;
    int exp_pkt_q[$];
    int exp_to_q[$];
    int exp_ov_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_hist = 0; m_cur = 0; m_nbits = 0; m_npk = 0; m_idle = 0;
            m_full = 0; m_held = 0; m_frames = 0;
            exp_pkt_q.delete();
            exp_to_q.delete();
            exp_ov_q.delete();
        end else begin
            m_cyc++;
            m_xfer = (m_full != 0 && pkt_ready) ? 1 : 0;
            m_load = 0;
            if (m_locked == 0) begin
                if (!enable) begin
                    m_hist = 0;
                end else if (bit_valid) begin
                    m_hist = ((m_hist * 2) + int'(bit_data)) % 256;
                    if (m_hist == SYNC) begin
                        m_locked = 1; m_nbits = 0; m_npk = 0; m_idle = 0; m_hist = 0;
                    end
                end
            end else if (!enable) begin
                m_locked = 0;
            end else if (bit_valid) begin
                m_idle = 0;
                m_cur = ((m_cur * 2) + int'(bit_data)) % 256;
                m_nbits++;
                if (m_nbits == 8) begin
                    m_nbits = 0;
                    if (m_full == 0 || m_xfer != 0) begin
                        m_load = 1;
                        m_held = m_cur;
                        exp_pkt_q.push_back(m_cur);
                        m_npk++;
                        if (m_npk == NPKTS) begin
                            m_locked = 0;
                            m_frames++;
                        end
                    end else begin
                        exp_ov_q.push_back(m_cyc);
                        m_locked = 0;
                    end
                end
            end else if (m_idle == GAP_MAX) begin
                exp_to_q.push_back(m_cyc);
                m_locked = 0;
            end else begin
                m_idle++;
            end
            if (m_load != 0) m_full = 1;
            else if (m_xfer != 0) m_full = 0;
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    int to_seen = 0;
    int ov_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("pkt_valid", pkt_valid, m_full);
            if (m_full != 0) check("pkt_data_held", pkt_data, m_held);
            check("sync_lock", sync_lock, m_locked);
            check("frame_count", frame_count, m_frames % 256);
            if (pkt_valid && pkt_ready) begin
                check("pkt_expected", exp_pkt_q.size() != 0, 1);
                if (exp_pkt_q.size() != 0) check("pkt_xfer_data", pkt_data, exp_pkt_q.pop_front());
            end
            if (timeout_err) begin
                to_seen++;
                check("timeout_expected", exp_to_q.size() != 0, 1);
                if (exp_to_q.size() != 0) check("timeout_cycle", m_cyc, exp_to_q.pop_front());
            end else if (exp_to_q.size() != 0 && exp_to_q[0] <= m_cyc) begin
                check("timeout_missing", 0, 1);
                void'(exp_to_q.pop_front());
            end
            if (overrun_err) begin
                ov_seen++;
                check("overrun_expected", exp_ov_q.size() != 0, 1);
                if (exp_ov_q.size() != 0) check("overrun_cycle", m_cyc, exp_ov_q.pop_front());
            end else if (exp_ov_q.size() != 0 && exp_ov_q[0] <= m_cyc) begin
                check("overrun_missing", 0, 1);
                void'(exp_ov_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_data  = b;
        tick();
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    int base_to, base_ov;
    int r;

    initial begin
        repeat (3) tick();
        check("reset_pkt_valid", pkt_valid, 0);
        check("reset_pkt_data", pkt_data, 0);
        check("reset_sync_lock", sync_lock, 0);
        check("reset_frame_count", frame_count, 0);
        check("reset_errs", {timeout_err, overrun_err}, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Clean frame, then a lock preceded by a non-matching byte.
        pkt_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hC3);
        repeat (10) tick();
        check("t1_frame_count", frame_count, 1);
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
        repeat (10) tick();
        check("t2_frame_count", frame_count, 2);

        // Output stalled: the second packet overruns.
        base_ov = ov_seen;
        pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
        repeat (5) tick();
        check("t3_overrun_once", ov_seen - base_ov, 1);
        check("t3_pkt_data", pkt_data, 8'h11);
        check("t3_frame_count", frame_count, 2);
        check("t3_hunt", sync_lock, 0);
        pkt_ready = 1'b1;
        repeat (5) tick();

        // Inter-bit gap timeout, then recovery.
        base_to = to_seen;
        send_byte(8'hA5); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (80) tick();
        check("t4_timeout_once", to_seen - base_to, 1);
        check("t4_no_pkt", pkt_valid, 0);
        send_byte(8'hA5); send_byte(8'h77); send_byte(8'h88);
        repeat (10) tick();

        // Asynchronous reset in the middle of a packet with a packet pending.
        pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h12); send_bit(1'b1); send_bit(1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_valid", pkt_valid, 0);
        check("t5_async_data", pkt_data, 0);
        check("t5_async_lock", sync_lock, 0);
        check("t5_async_frames", frame_count, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        tick();
        send_byte(8'hA5); send_byte(8'h34); send_byte(8'h56);
        repeat (10) tick();
        check("t5_relock_frames", frame_count, 1);

        // Disable mid-frame while a packet waits downstream.
        base_to = to_seen;
        base_ov = ov_seen;
        pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h99); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        send_byte(8'h33);
        check("t6_pkt_kept", pkt_valid, 1);
        check("t6_pkt_data", pkt_data, 8'h99);
        check("t6_no_lock", sync_lock, 0);
        check("t6_no_errs", (to_seen - base_to) + (ov_seen - base_ov), 0);
        pkt_ready = 1'b1;
        repeat (4) tick();
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55);
        repeat (10) tick();

        // Random traffic: sync bursts, random bits, stalls, disables and long gaps.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            pkt_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 49) != 0);
            if (r < 12) send_byte(8'hA5);
            else if (r < 75) send_bit(1'($urandom_range(0, 1)));
            else if (r < 78) repeat (70) tick();
            else tick();
        end

        enable = 1'b1;
        pkt_ready = 1'b1;
        repeat (100) tick();
        check("end_pkt_q_drained", exp_pkt_q.size(), 0);
        check("end_to_q_drained", exp_to_q.size(), 0);
        check("end_ov_q_drained", exp_ov_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
